dac_spi_multich: RTL and testbench

//  Parametrised successor to the single-value AD5328 driver/core pair. Holds NUM_CH

---
 rtl/dac_spi_multich_pkg.sv | 54 +++++
 rtl/dac_spi_multich_spi_tx_shifter.sv | 86 ++++++++
 rtl/dac_spi_multich.sv | 175 +++++++++++++++++
 tb/tb_dac_spi_multich.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_multich_pkg.sv
`default_nettype none
//==============================================================================
// dac_spi_pkg: frame layout, FSM state type and round-robin helper for dac_spi_multich
// Revision: 1.0
//==============================================================================
package dac_spi_pkg;

  localparam int FRAME_W      = 16;
  localparam int DATA_FIELD_W = 12;
  localparam int ADDR_LSB     = 12;
  localparam int ADDR_FIELD_W = 3;
  localparam int CMD_BIT      = 15;
  localparam int MAX_CH       = 8;
  localparam int CH_IDX_W     = 3;

  typedef enum logic [2:0] {
    ST_WAIT_EN = 3'd0,
    ST_IDLE    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_GAP     = 3'd4,
    ST_LDAC    = 3'd5
  } state_e;

  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [ADDR_FIELD_W-1:0] addr,
    input logic [DATA_FIELD_W-1:0] data_lj
  );
    logic [FRAME_W-1:0] f;
    f                              = '0;
    f[CMD_BIT]                     = 1'b0;
    f[ADDR_LSB +: ADDR_FIELD_W]    = addr;
    f[DATA_FIELD_W-1:0]            = data_lj;
    return f;
  endfunction

  // Scans downward so the requester closest after 'last' is the one left in 'pick'.
  function automatic logic [CH_IDX_W-1:0] rr_pick(
    input logic [MAX_CH-1:0]   req,
    input logic [CH_IDX_W-1:0] last,
    input int                  num_ch
  );
    logic [CH_IDX_W-1:0] pick;
    int                  idx;
    pick = last;
    for (int k = num_ch; k >= 1; k--) begin
      idx = (int'(last) + k) % num_ch;
      if (req[idx[CH_IDX_W-1:0]]) pick = idx[CH_IDX_W-1:0];
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dac_spi_multich_spi_tx_shifter.sv
`default_nettype none
//==============================================================================
// spi_tx_shifter: serialises one 16-bit word MSB first, sclk idles high
// Revision: 1.0
//==============================================================================
module spi_tx_shifter
  import dac_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] word,
  output logic               sclk,
  output logic               dout,
  output logic               done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  logic               active_q, active_d;
  logic               sclk_q,   sclk_d;
  logic [FRAME_W-1:0] shreg_q,  shreg_d;
  logic [DIV_W-1:0]   div_q,    div_d;
  logic [BIT_W-1:0]   bit_q,    bit_d;

  always_comb begin
    active_d = active_q;
    sclk_d   = sclk_q;
    shreg_d  = shreg_q;
    div_d    = div_q;
    bit_d    = bit_q;
    done     = 1'b0;
    if (start && !active_q) begin
      active_d = 1'b1;
      shreg_d  = word;
      div_d    = '0;
      bit_d    = '0;
      sclk_d   = 1'b1;
    end else if (active_q) begin
      div_d = div_q + 1'b1;
      if (div_q == DIV_LAST) begin
        div_d = '0;
        if (sclk_q) begin
          sclk_d = 1'b0;
        end else begin
          sclk_d = 1'b1;
          if (bit_q == BIT_LAST) begin
            active_d = 1'b0;
            done     = 1'b1;
            shreg_d  = '0;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b1;
      shreg_q  <= '0;
      div_q    <= '0;
      bit_q    <= '0;
    end else begin
      active_q <= active_d;
      sclk_q   <= sclk_d;
      shreg_q  <= shreg_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
    end
  end

  // MSB is presented during the load cycle, before the shift register is filled.
  assign sclk = sclk_q;
  assign dout = active_q ? shreg_q[FRAME_W-1] : (start & word[FRAME_W-1]);

endmodule
`default_nettype wire

// File: rtl/dac_spi_multich.sv
`default_nettype none
//==============================================================================
// dac_spi_multich: multi-channel DAC set-point holder with round-robin SPI writer
// Revision: 1.0
//==============================================================================
module dac_spi_multich
  import dac_spi_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int DATA_W    = 12,
  parameter int ADDR_W    = 3,
  parameter int CLK_DIV   = 4,
  parameter int SYNC_GAP  = 2,
  parameter int EN_DELAY  = 101,
  parameter int LDAC_MODE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_set,
  input  logic [NUM_CH*DATA_W-1:0] ch_value,
  output logic [NUM_CH-1:0]        ch_pending,
  output logic                     busy,
  output logic                     hen,
  output logic                     sync_n,
  output logic                     sclk,
  output logic                     dout,
  output logic                     ldac_n
);

  localparam int EN_W    = (EN_DELAY > 0) ? $clog2(EN_DELAY + 1) : 1;
  localparam int TMR_MAX = (SYNC_GAP > CLK_DIV) ? SYNC_GAP : CLK_DIV;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [EN_W-1:0]  EN_LAST   = EN_W'(EN_DELAY);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(SYNC_GAP - 1);
  localparam logic [TMR_W-1:0] LDAC_LAST = TMR_W'(CLK_DIV - 1);
  localparam logic             LDAC_IDLE = (LDAC_MODE != 0);

  state_e                state_q,   state_d;
  logic [EN_W-1:0]       en_cnt_q,  en_cnt_d;
  logic                  hen_q,     hen_d;
  logic [NUM_CH-1:0]     pending_q, pending_d;
  logic [CH_IDX_W-1:0]   last_q,    last_d;
  logic [TMR_W-1:0]      tmr_q,     tmr_d;
  logic                  sync_n_q,  sync_n_d;
  logic                  busy_q,    busy_d;
  logic                  ldac_n_q,  ldac_n_d;
  logic [DATA_W-1:0]     shadow_q [NUM_CH];
  logic [DATA_W-1:0]     shadow_d [NUM_CH];

  logic [MAX_CH-1:0]       req_w;
  logic [CH_IDX_W-1:0]     grant_w;
  logic [ADDR_FIELD_W-1:0] addr_w;
  logic [DATA_FIELD_W-1:0] data_lj_w;
  logic [FRAME_W-1:0]      frame_w;
  logic                    tx_start_w;
  logic                    tx_done_w;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_shadow
      assign shadow_d[i] = ch_set[i] ? ch_value[i*DATA_W +: DATA_W] : shadow_q[i];
    end
  endgenerate

  always_comb begin
    req_w               = '0;
    req_w[NUM_CH-1:0]   = pending_q;
    grant_w             = rr_pick(req_w, last_q, NUM_CH);
    addr_w              = '0;
    addr_w[ADDR_W-1:0]  = grant_w[ADDR_W-1:0];
    data_lj_w           = DATA_FIELD_W'(shadow_q[grant_w]) << (DATA_FIELD_W - DATA_W);
    frame_w             = build_frame(addr_w, data_lj_w);
  end

  assign tx_start_w = (state_q == ST_LOAD);

  // A set landing in the LOAD cycle re-arms the channel after the clear.
  always_comb begin
    pending_d = pending_q;
    last_d    = last_q;
    if (state_q == ST_LOAD) begin
      pending_d[grant_w] = 1'b0;
      last_d             = grant_w;
    end
    pending_d = pending_d | ch_set;
  end

  always_comb begin
    en_cnt_d = (en_cnt_q == EN_LAST) ? en_cnt_q : en_cnt_q + 1'b1;
    hen_d    = hen_q | (en_cnt_q == EN_LAST);
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      ST_WAIT_EN: if (hen_q) state_d = ST_IDLE;
      ST_IDLE:    if (|pending_q) state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (tx_done_w) begin
          state_d = ST_GAP;
          tmr_d   = '0;
        end
      end
      ST_GAP: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == GAP_LAST) begin
          tmr_d = '0;
          if (|pending_q)          state_d = ST_LOAD;
          else if (LDAC_MODE != 0) state_d = ST_LDAC;
          else                     state_d = ST_IDLE;
        end
      end
      ST_LDAC: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == LDAC_LAST) begin
          tmr_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_WAIT_EN;
    endcase

    // Outputs are registered from the next state so they leave the flops glitch-free.
    sync_n_d = !((state_d == ST_LOAD) || (state_d == ST_SHIFT));
    busy_d   = !((state_d == ST_IDLE) || (state_d == ST_WAIT_EN));
    ldac_n_d = LDAC_IDLE ? (state_d != ST_LDAC) : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_WAIT_EN;
      en_cnt_q  <= '0;
      hen_q     <= 1'b0;
      pending_q <= '0;
      last_q    <= CH_IDX_W'(NUM_CH - 1);
      tmr_q     <= '0;
      sync_n_q  <= 1'b1;
      busy_q    <= 1'b0;
      ldac_n_q  <= LDAC_IDLE;
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      en_cnt_q  <= en_cnt_d;
      hen_q     <= hen_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      tmr_q     <= tmr_d;
      sync_n_q  <= sync_n_d;
      busy_q    <= busy_d;
      ldac_n_q  <= ldac_n_d;
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  spi_tx_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (tx_start_w),
    .word  (frame_w),
    .sclk  (sclk),
    .dout  (dout),
    .done  (tx_done_w)
  );

  assign ch_pending = pending_q;
  assign busy       = busy_q;
  assign hen        = hen_q;
  assign sync_n     = sync_n_q;
  assign ldac_n     = ldac_n_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_multich.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// tb_dac_spi_multich: directed + random stimulus against a frame-level reference model
// Revision: 1.0
//==============================================================================
module tb_dac_spi_multich;

  localparam int NCH  = 8;
  localparam int DW   = 12;
  localparam int DWB  = 10;
  localparam int CDIV = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]     ch_set   = '0;
  logic [NCH*DW-1:0]  ch_value = '0;
  logic [NCH-1:0]     ch_pending;
  logic               busy, hen, sync_n, sclk, dout, ldac_n;

  logic [NCH-1:0]     ch_set_b   = '0;
  logic [NCH*DWB-1:0] ch_value_b = '0;
  logic [NCH-1:0]     ch_pending_b;
  logic               busy_b, hen_b, sync_n_b, sclk_b, dout_b, ldac_n_b;

  dac_spi_multich #(
    .NUM_CH(NCH), .DATA_W(DW), .ADDR_W(3), .CLK_DIV(CDIV),
    .SYNC_GAP(2), .EN_DELAY(101), .LDAC_MODE(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .ch_set(ch_set), .ch_value(ch_value),
    .ch_pending(ch_pending), .busy(busy), .hen(hen), .sync_n(sync_n),
    .sclk(sclk), .dout(dout), .ldac_n(ldac_n)
  );

  dac_spi_multich #(
    .NUM_CH(NCH), .DATA_W(DWB), .ADDR_W(3), .CLK_DIV(CDIV),
    .SYNC_GAP(2), .EN_DELAY(101), .LDAC_MODE(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .ch_set(ch_set_b), .ch_value(ch_value_b),
    .ch_pending(ch_pending_b), .busy(busy_b), .hen(hen_b), .sync_n(sync_n_b),
    .sclk(sclk_b), .dout(dout_b), .ldac_n(ldac_n_b)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: latest value and outstanding flag per channel, plus last served.
  logic [DW-1:0]     m_shadow [NCH];
  logic [NCH-1:0]    m_pend;
  int                m_last;
  logic              in_load;
  int                load_ch;
  logic              prev_sync;
  logic [NCH-1:0]    nxt_set = '0;
  logic [NCH*DW-1:0] nxt_val = '0;
  logic [15:0]       exp_q[$];

  // Pin-level observation of dut_a
  logic [15:0] got_q[$];
  int          nbits_q[$];
  int          len_q[$];
  int          pulse_q[$];
  logic [15:0] sh_a    = '0;
  int          nb_a    = 0;
  int          low_a   = 0;
  int          early_a = 0;
  int          lcur_a  = 0;

  always @(negedge sync_n) begin
    nb_a  = 0;
    low_a = 0;
    if (hen !== 1'b1) early_a++;
  end
  always @(negedge sclk) if (sync_n === 1'b0) begin
    sh_a = {sh_a[14:0], dout};
    nb_a++;
  end
  always @(posedge sync_n) if (rst_n === 1'b1) begin
    got_q.push_back(sh_a);
    nbits_q.push_back(nb_a);
    len_q.push_back(low_a);
  end
  always @(negedge clk) begin
    if (sync_n === 1'b0) low_a++;
    if (rst_n === 1'b1) begin
      if (ldac_n === 1'b0) lcur_a++;
      else if (lcur_a != 0) begin
        pulse_q.push_back(lcur_a);
        lcur_a = 0;
      end
    end else lcur_a = 0;
  end

  // Pin-level observation of dut_b
  logic [15:0] got_b_q[$];
  logic [15:0] sh_b       = '0;
  int          ldac_b_bad = 0;
  always @(negedge sclk_b) if (sync_n_b === 1'b0) sh_b = {sh_b[14:0], dout_b};
  always @(posedge sync_n_b) if (rst_n === 1'b1) got_b_q.push_back(sh_b);
  always @(negedge clk) if (rst_n === 1'b1 && ldac_n_b !== 1'b0) ldac_b_bad++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int model_pick();
    for (int k = 1; k <= NCH; k++)
      if (m_pend[(m_last + k) % NCH]) return (m_last + k) % NCH;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_shadow[i] = '0;
    m_pend    = '0;
    m_last    = NCH - 1;
    in_load   = 1'b0;
    load_ch   = 0;
    prev_sync = 1'b1;
    nxt_set   = '0;
  endtask

  task automatic set_ch(input int ch, input logic [DW-1:0] val);
    nxt_set[ch]           = 1'b1;
    nxt_val[ch*DW +: DW]  = val;
  endtask

  task automatic tick();
    ch_set   = nxt_set;
    ch_value = nxt_val;
    @(posedge clk);
    if (in_load) m_pend[load_ch] = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (nxt_set[i]) begin
        m_shadow[i] = nxt_val[i*DW +: DW];
        m_pend[i]   = 1'b1;
      end
    in_load = 1'b0;
    nxt_set = '0;
    #1;
    ch_set = '0;
    if (prev_sync && !sync_n) begin
      load_ch = model_pick();
      check("load_has_pending", 32'(load_ch >= 0), 32'd1);
      if (load_ch >= 0) begin
        in_load = 1'b1;
        exp_q.push_back({1'b0, 3'(load_ch), m_shadow[load_ch]});
        m_last = load_ch;
      end
    end
    prev_sync = sync_n;
    check("pending", 32'(ch_pending), 32'(m_pend));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(busy === 1'b0 && ch_pending === '0 && !in_load && sync_n === 1'b1) && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 3000), 32'd1);
    repeat (2) tick();
  endtask

  task automatic compare_frames(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check({tag, "_frame"},   32'(got_q[i]),   32'(exp_q[i]));
      check({tag, "_bits"},    32'(nbits_q[i]), 32'd16);
      check({tag, "_synclow"}, 32'(len_q[i]),   32'(1 + 32 * CDIV));
    end
    got_q.delete();
    exp_q.delete();
    nbits_q.delete();
    len_q.delete();
  endtask

  task automatic check_pulses(input string tag, input int n_exp);
    if (n_exp >= 0) check({tag, "_ldac_count"}, 32'(pulse_q.size()), 32'(n_exp));
    else            check({tag, "_ldac_any"},   32'(pulse_q.size() > 0), 32'd1);
    foreach (pulse_q[i]) check({tag, "_ldac_width"}, 32'(pulse_q[i]), 32'(CDIV));
    pulse_q.delete();
  endtask

  task automatic power_up(input string tag, input int set_at, input int ch, input logic [DW-1:0] val);
    for (int c = 1; c <= 101; c++) begin
      if (c == set_at) set_ch(ch, val);
      tick();
    end
    check({tag, "_hen_before"},  32'(hen),    32'd0);
    check({tag, "_sync_before"}, 32'(sync_n), 32'd1);
    tick();
    check({tag, "_hen_after"},   32'(hen),    32'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int busy_cnt;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_hen",     32'(hen),        32'd0);
    check("rst_sync_n",  32'(sync_n),     32'd1);
    check("rst_sclk",    32'(sclk),       32'd1);
    check("rst_dout",    32'(dout),       32'd0);
    check("rst_busy",    32'(busy),       32'd0);
    check("rst_pending", 32'(ch_pending), 32'd0);
    check("rst_ldac_a",  32'(ldac_n),     32'd1);
    check("rst_ldac_b",  32'(ldac_n_b),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Power-up gating and a single frame
    power_up("t1", 10, 3, 12'hABC);
    wait_idle("t1");
    check("t1_first_frame", 32'(got_q.size() > 0 ? got_q[0] : 16'h0), 32'h3ABC);
    check("t1_early_sync",  32'(early_a), 32'd0);
    compare_frames("t1");
    check_pulses("t1", 1);

    // Round-robin order from last_served = 5
    set_ch(5, 12'($urandom));
    tick();
    wait_idle("t2a");
    compare_frames("t2a");
    check_pulses("t2a", 1);
    set_ch(1, 12'($urandom));
    set_ch(5, 12'($urandom));
    set_ch(6, 12'($urandom));
    tick();
    wait_idle("t2");
    check("t2_n",    32'(got_q.size()), 32'd3);
    check("t2_ord0", 32'(got_q.size() > 0 ? got_q[0][14:12] : 3'd0), 32'd6);
    check("t2_ord1", 32'(got_q.size() > 1 ? got_q[1][14:12] : 3'd0), 32'd1);
    check("t2_ord2", 32'(got_q.size() > 2 ? got_q[2][14:12] : 3'd0), 32'd5);
    compare_frames("t2");
    check_pulses("t2", 1);

    // Latest value wins while pending behind another frame
    set_ch(7, 12'($urandom));
    tick();
    set_ch(2, 12'h100);
    tick();
    repeat (20) tick();
    set_ch(2, 12'h200);
    tick();
    wait_idle("t3");
    check("t3_n",      32'(got_q.size()), 32'd2);
    check("t3_latest", 32'(got_q.size() > 1 ? got_q[1] : 16'h0), 32'h2200);
    compare_frames("t3");
    check_pulses("t3", 1);

    // Set in the channel's own LOAD cycle
    set_ch(4, 12'h123);
    tick();
    n = 0;
    while (!in_load && n < 50) begin
      tick();
      n++;
    end
    check("t4_load_seen", 32'(in_load), 32'd1);
    set_ch(4, 12'h055);
    tick();
    wait_idle("t4");
    check("t4_n",   32'(got_q.size()), 32'd2);
    check("t4_old", 32'(got_q.size() > 0 ? got_q[0] : 16'h0), 32'h4123);
    check("t4_new", 32'(got_q.size() > 1 ? got_q[1] : 16'h0), 32'h4055);
    compare_frames("t4");
    check_pulses("t4", 1);

    // Random traffic against the model
    for (int t = 0; t < 400; t++) begin
      nxt_set = 8'($urandom & $urandom & $urandom);
      for (int i = 0; i < NCH; i++) nxt_val[i*DW +: DW] = 12'($urandom);
      tick();
    end
    wait_idle("rnd");
    compare_frames("rnd");
    check_pulses("rnd", -1);

    // Asynchronous reset in the middle of a frame
    set_ch(0, 12'h5A5);
    tick();
    n = 0;
    while (!in_load && n < 50) begin
      tick();
      n++;
    end
    repeat (20) tick();
    check("t5_in_shift", 32'(sync_n), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_sync_n",  32'(sync_n),     32'd1);
    check("t5_sclk",    32'(sclk),       32'd1);
    check("t5_hen",     32'(hen),        32'd0);
    check("t5_pending", 32'(ch_pending), 32'd0);
    check("t5_busy",    32'(busy),       32'd0);
    check("t5_ldac",    32'(ldac_n),     32'd1);
    model_reset();
    got_q.delete();
    exp_q.delete();
    nbits_q.delete();
    len_q.delete();
    pulse_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    early_a = 0;
    power_up("t5", 1, 1, 12'h321);
    wait_idle("t5");
    check("t5_early_sync", 32'(early_a), 32'd0);
    check("t5_frame", 32'(got_q.size() > 0 ? got_q[0] : 16'h0), 32'h1321);
    compare_frames("t5");
    check_pulses("t5", 1);

    // Transparent-LDAC instance with 10-bit data
    ch_set_b[0]      = 1'b1;
    ch_value_b[9:0]  = 10'h3FF;
    @(posedge clk);
    #1;
    ch_set_b = '0;
    busy_cnt = 0;
    for (int t = 0; t < 150; t++) begin
      tick();
      if (busy_b === 1'b1) busy_cnt++;
    end
    check("t6_n",     32'(got_b_q.size()), 32'd1);
    check("t6_frame", 32'(got_b_q.size() > 0 ? got_b_q[0] : 16'h0), 32'h0FFC);
    check("t6_busy",  32'(busy_cnt), 32'(1 + 32 * CDIV + 2));
    check("t6_ldac",  32'(ldac_b_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
